dcm_clkgen_prog: RTL



---
 rtl/dcm_clkgen_prog.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dcm_clkgen_prog.sv
// DCM_CLKGEN serial programming sequencer: shifts LoadD, LoadM and GO over PROGEN/PROGDATA,
// then waits for PROGDONE, with a one-deep buffer for requests that arrive while busy.
module dcm_clkgen_prog #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dcm_set,
    input  logic [7:0] multi,
    input  logic [7:0] div,
    input  logic       progdone,
    output logic       progen,
    output logic       progdata,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoadD = 3'd1;
    localparam logic [2:0] StGap1  = 3'd2;
    localparam logic [2:0] StLoadM = 3'd3;
    localparam logic [2:0] StGap2  = 3'd4;
    localparam logic [2:0] StGo    = 3'd5;
    localparam logic [2:0] StWait  = 3'd6;

    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        seen_low_q, seen_low_d;
    logic [7:0]  wm_q, wm_d, wd_q, wd_d;
    logic [7:0]  pm_q, pm_d, pdv_q, pdv_d;
    logic        pend_q, pend_d;
    logic        progen_q, progen_d, progdata_q, progdata_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [3:0]  bidx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 4'd1;
        tmo_d      = tmo_q + 16'd1;
        seen_low_d = seen_low_q;
        wm_d       = wm_q;
        wd_d       = wd_q;
        pm_d       = pm_q;
        pdv_d      = pdv_q;
        pend_d     = pend_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        // Requests outside IDLE land in the pending buffer; last one wins.
        if (dcm_set && state_q != StIdle) begin
            pend_d = 1'b1;
            pm_d   = multi;
            pdv_d  = div;
        end

        case (state_q)
            StIdle: begin
                if (dcm_set) begin
                    if (multi == 8'd0) begin
                        err_d = 1'b1;
                    end else begin
                        wm_d    = multi;
                        wd_d    = div;
                        pend_d  = 1'b0;
                        state_d = StLoadD;
                    end
                end else if (pend_q) begin
                    pend_d = 1'b0;
                    if (pm_q == 8'd0) begin
                        err_d = 1'b1;
                    end else begin
                        wm_d    = pm_q;
                        wd_d    = pdv_q;
                        state_d = StLoadD;
                    end
                end
            end
            StLoadD: if (cnt_q == 4'd9) state_d = StGap1;
            StGap1:  state_d = StLoadM;
            StLoadM: if (cnt_q == 4'd9) state_d = StGap2;
            StGap2:  state_d = StGo;
            StGo:    state_d = StWait;
            StWait: begin
                if (!progdone) seen_low_d = 1'b1;
                if (seen_low_q && progdone) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d      = 4'd0;
            tmo_d      = 16'd0;
            seen_low_d = 1'b0;
        end

        // Outputs are registered, so they are derived from the next state and counter.
        bidx       = cnt_d - 4'd2;
        busy_d     = (state_d != StIdle);
        progen_d   = 1'b0;
        progdata_d = 1'b0;
        case (state_d)
            StLoadD: begin
                progen_d   = 1'b1;
                progdata_d = (cnt_d == 4'd0) ? 1'b1 :
                             (cnt_d == 4'd1) ? 1'b0 : wd_d[bidx[2:0]];
            end
            StLoadM: begin
                progen_d   = 1'b1;
                progdata_d = (cnt_d <= 4'd1) ? 1'b1 : wm_d[bidx[2:0]];
            end
            StGo:    progen_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            tmo_q      <= 16'd0;
            seen_low_q <= 1'b0;
            wm_q       <= 8'd0;
            wd_q       <= 8'd0;
            pm_q       <= 8'd0;
            pdv_q      <= 8'd0;
            pend_q     <= 1'b0;
            progen_q   <= 1'b0;
            progdata_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            seen_low_q <= seen_low_d;
            wm_q       <= wm_d;
            wd_q       <= wd_d;
            pm_q       <= pm_d;
            pdv_q      <= pdv_d;
            pend_q     <= pend_d;
            progen_q   <= progen_d;
            progdata_q <= progdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign progen   = progen_q;
    assign progdata = progdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
